// File: rtl/demux4_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux4_pkg
//  Purpose  : Shared constants and types for the demux4_stream block.
//  Config   : DEMUX4_RR_EN (consumed by the top level only)
//  Revision : 1.0 - initial release
// ============================================================================
package demux4_pkg;

  localparam int N_OUT = 4;  // number of output slots
  localparam int SEL_W = 2;  // destination index width

  typedef logic [SEL_W-1:0] sel_t;

endpackage : demux4_pkg
`default_nettype wire

// File: rtl/demux4_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux4_stream_if
//  Purpose  : Producer-side and consumer-side handshake bundle of the
//             4-way stream demultiplexer. Output lanes are packed arrays
//             indexed by slot number.
//  Config   : DEMUX4_RR_EN (io_selector is ignored when defined)
//  Revision : 1.0 - initial release
// ============================================================================
interface demux4_stream_if #(
  parameter int WIDTH = 8
);
  import demux4_pkg::*;

  // producer side
  sel_t                         io_selector;
  logic                         io_in_valid;
  logic                         io_in_ready;
  logic [WIDTH-1:0]             io_in_bits;

  // consumer side, one lane per slot
  logic [N_OUT-1:0]             io_out_valid;
  logic [N_OUT-1:0]             io_out_ready;
  logic [N_OUT-1:0][WIDTH-1:0]  io_out_bits;

  // environment view: drives beats in, takes beats out
  modport master (
    output io_selector, io_in_valid, io_in_bits, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits
  );

  // demultiplexer view
  modport slave (
    input  io_selector, io_in_valid, io_in_bits, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits
  );

endinterface : demux4_stream_if
`default_nettype wire

// File: rtl/demux4_stream_slot.sv
`default_nettype none
// ============================================================================
//  Module   : demux_slot
//  Purpose  : One-entry output buffer. Loads a beat when load_i is high,
//             presents it until the consumer takes it. A load in the same
//             cycle as a drain replaces the data without a bubble.
//  Config   : none
//  Revision : 1.0 - initial release
// ============================================================================
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // next state: load wins over drain so flow-through keeps the slot full
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (full_q && out_ready_i) begin
      full_d = 1'b0;
    end
  end

  // slot state register with synchronous clear
  always_ff @(posedge clock) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid_o = full_q;
  assign data_o      = data_q;
  assign full_o      = full_q;

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : demux4_stream
//  Purpose  : 1-to-4 stream demultiplexer. Each input beat is steered to one
//             of four one-entry output slots; a full, stalled slot only
//             blocks beats aimed at it. Counts accepted beats.
//  Config   : DEMUX4_RR_EN - destination comes from an internal round-robin
//             pointer advanced per accepted beat; io_selector is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module demux4_stream
  import demux4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  demux4_stream_if.slave    io,
  output logic [CNT_W-1:0]  io_count
);

  sel_t             dest;
  logic             accept;
  logic [N_OUT-1:0] slot_load;
  logic [N_OUT-1:0] slot_full;
  logic [CNT_W-1:0] count_q, count_d;

`ifdef DEMUX4_RR_EN
  sel_t rr_q, rr_d;
  logic unused_selector;

  assign unused_selector = ^io.io_selector;
  assign dest            = rr_q;

  // pointer advances only on an accepted beat, wrapping 3 -> 0
  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = rr_q + sel_t'(1);
  end

  // round-robin pointer register
  always_ff @(posedge clock) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`else
  assign dest = io.io_selector;
`endif

  // ready depends only on the target slot, never on io_in_valid
  assign io.io_in_ready = !reset && (!slot_full[dest] || io.io_out_ready[dest]);
  assign accept         = io.io_in_valid && io.io_in_ready;

  // one-hot load for the addressed slot
  always_comb begin
    slot_load = '0;
    slot_load[dest] = accept;
  end

  for (genvar n = 0; n < N_OUT; n++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clock       (clock),
      .reset       (reset),
      .load_i      (slot_load[n]),
      .data_i      (io.io_in_bits),
      .out_ready_i (io.io_out_ready[n]),
      .out_valid_o (io.io_out_valid[n]),
      .data_o      (io.io_out_bits[n]),
      .full_o      (slot_full[n])
    );
  end

  // accepted-beat counter, wraps naturally
  always_comb begin
    count_d = count_q;
    if (accept) count_d = count_q + CNT_W'(1);
  end

  // counter register
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign io_count = count_q;

endmodule : demux4_stream
`default_nettype wire

// File: tb/tb_demux4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux4_stream
//  Purpose  : Self-checking bench for demux4_stream: directed scenarios plus
//             randomized traffic against per-destination queue model.
//  Config   : DEMUX4_RR_EN (round-robin build)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux4_stream;
  import demux4_pkg::*;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] io_count;
  int            total = 0;
  int            bad   = 0;

  demux4_stream_if #(.WIDTH(W)) io ();

  demux4_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock    (clock),
    .reset    (reset),
    .io       (io),
    .io_count (io_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    io.io_in_valid  = 1'b0;
    io.io_selector  = '0;
    io.io_in_bits   = '0;
    io.io_out_ready = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // send one beat in a single cycle, then go idle on the input side
  task automatic send(input int sel, input logic [W-1:0] bits);
    io.io_selector = sel_t'(sel);
    io.io_in_bits  = bits;
    io.io_in_valid = 1'b1;
    tick();
    io.io_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    io.io_in_valid = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (io.io_in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready got %b want 0", io.io_in_ready);
    end
    total++;
    if (io.io_out_valid !== 4'b0000) begin
      bad++; $display("FAIL reset_out_valid got %b want 0000", io.io_out_valid);
    end
    total++;
    if (io_count !== 16'd0) begin
      bad++; $display("FAIL reset_count got %0d want 0", io_count);
    end
    reset = 1'b0;
    idle();
  endtask

`ifndef DEMUX4_RR_EN
  task automatic test_manual_steer();
    do_reset();
    send(2, 8'hA5);
    total++;
    if (io.io_out_valid !== 4'b0100) begin
      bad++; $display("FAIL steer_valid got %b want 0100", io.io_out_valid);
    end
    total++;
    if (io.io_out_bits[2] !== 8'hA5) begin
      bad++; $display("FAIL steer_bits got %h want a5", io.io_out_bits[2]);
    end
    total++;
    if (io_count !== 16'd1) begin
      bad++; $display("FAIL steer_count got %0d want 1", io_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send(1, 8'h77);
    io.io_selector = 2'd1;
    io.io_in_bits  = 8'h99;
    io.io_in_valid = 1'b1;
    #1;
    total++;
    if (io.io_in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_blocked_ready got %b want 0", io.io_in_ready);
    end
    tick();
    total++;
    if (io.io_out_bits[1] !== 8'h77 || io_count !== 16'd1) begin
      bad++; $display("FAIL bp_hold got bits=%h cnt=%0d want bits=77 cnt=1",
                      io.io_out_bits[1], io_count);
    end
    io.io_selector = 2'd3;
    io.io_in_bits  = 8'h3C;
    #1;
    total++;
    if (io.io_in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_other_ready got %b want 1", io.io_in_ready);
    end
    tick();
    io.io_in_valid = 1'b0;
    total++;
    if (io.io_out_valid !== 4'b1010 || io.io_out_bits[3] !== 8'h3C || io_count !== 16'd2) begin
      bad++; $display("FAIL bp_other got valid=%b bits=%h cnt=%0d want 1010 3c 2",
                      io.io_out_valid, io.io_out_bits[3], io_count);
    end
  endtask

  task automatic test_flow_through();
    do_reset();
    send(0, 8'h11);
    io.io_out_ready = 4'b0001;
    io.io_selector  = 2'd0;
    io.io_in_bits   = 8'h22;
    io.io_in_valid  = 1'b1;
    #1;
    total++;
    if (io.io_in_ready !== 1'b1) begin
      bad++; $display("FAIL flow_ready got %b want 1", io.io_in_ready);
    end
    tick();
    idle();
    total++;
    if (io.io_out_valid[0] !== 1'b1 || io.io_out_bits[0] !== 8'h22 || io_count !== 16'd2) begin
      bad++; $display("FAIL flow_slot0 got valid=%b bits=%h cnt=%0d want 1 22 2",
                      io.io_out_valid[0], io.io_out_bits[0], io_count);
    end
  endtask
`endif

  task automatic test_reset_mid();
`ifdef DEMUX4_RR_EN
    logic [3:0] fill_mask  = 4'b0011;
    logic [3:0] after_mask = 4'b0001;
    int         after_slot = 0;
`else
    logic [3:0] fill_mask  = 4'b0101;
    logic [3:0] after_mask = 4'b0010;
    int         after_slot = 1;
`endif
    do_reset();
    send(0, 8'h5A);
    send(2, 8'h6B);
    total++;
    if (io.io_out_valid !== fill_mask) begin
      bad++; $display("FAIL mid_fill got %b want %b", io.io_out_valid, fill_mask);
    end
    reset = 1'b1;
    io.io_out_ready = 4'b1111;
    tick();
    reset = 1'b0;
    io.io_out_ready = 4'b0000;
    total++;
    if (io.io_out_valid !== 4'b0000 || io_count !== 16'd0) begin
      bad++; $display("FAIL mid_cleared got valid=%b cnt=%0d want 0000 0",
                      io.io_out_valid, io_count);
    end
    send(1, 8'hC3);
    total++;
    if (io.io_out_valid !== after_mask || io.io_out_bits[after_slot] !== 8'hC3 ||
        io_count !== 16'd1) begin
      bad++; $display("FAIL mid_after got valid=%b bits=%h cnt=%0d want %b c3 1",
                      io.io_out_valid, io.io_out_bits[after_slot], io_count, after_mask);
    end
  endtask

`ifdef DEMUX4_RR_EN
  task automatic test_round_robin();
    do_reset();
    io.io_out_ready = 4'b1111;
    for (int i = 1; i <= 6; i++) begin
      logic [3:0] want_mask;
      int         slot;
      slot      = (i - 1) % 4;
      want_mask = 4'b0001 << slot;
      send(0, W'(i));
      total++;
      if (io.io_out_valid !== want_mask || io.io_out_bits[slot] !== W'(i)) begin
        bad++; $display("FAIL rr_beat%0d got valid=%b bits=%h want %b %h",
                        i, io.io_out_valid, io.io_out_bits[slot], want_mask, W'(i));
      end
    end
    total++;
    if (io_count !== 16'd6) begin
      bad++; $display("FAIL rr_count got %0d want 6", io_count);
    end
    idle();
  endtask
`endif

  // randomized traffic; the model is one FIFO per destination holding at most one beat
  task automatic test_random();
    logic [W-1:0] mq [N_OUT][$];
    int           m_count;
    int           m_rr;
    do_reset();
    for (int n = 0; n < N_OUT; n++) mq[n].delete();
    m_count = 0;
    m_rr    = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int   d;
      logic exp_ready;
      logic acc;
      reset           = ($urandom_range(0, 39) == 0);
      io.io_in_valid  = $urandom_range(0, 2) != 0;
      io.io_selector  = sel_t'($urandom_range(0, 3));
      io.io_in_bits   = W'($urandom);
      io.io_out_ready = 4'($urandom);
      #1;
`ifdef DEMUX4_RR_EN
      d = m_rr;
`else
      d = int'(io.io_selector);
`endif
      exp_ready = !reset && (mq[d].size() == 0 || io.io_out_ready[d]);
      total++;
      if (io.io_in_ready !== exp_ready) begin
        bad++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, io.io_in_ready, exp_ready);
      end
      for (int n = 0; n < N_OUT; n++) begin
        total++;
        if (io.io_out_valid[n] !== (mq[n].size() != 0)) begin
          bad++; $display("FAIL rand_valid%0d cyc=%0d got %b want %b",
                          n, cyc, io.io_out_valid[n], mq[n].size() != 0);
        end else if (mq[n].size() != 0 && io.io_out_bits[n] !== mq[n][0]) begin
          bad++; $display("FAIL rand_bits%0d cyc=%0d got %h want %h",
                          n, cyc, io.io_out_bits[n], mq[n][0]);
        end
      end
      total++;
      if (io_count !== CW'(m_count)) begin
        bad++; $display("FAIL rand_count cyc=%0d got %0d want %0d", cyc, io_count, m_count);
      end
      acc = io.io_in_valid && exp_ready;
      if (reset) begin
        for (int n = 0; n < N_OUT; n++) mq[n].delete();
        m_count = 0;
        m_rr    = 0;
      end else begin
        for (int n = 0; n < N_OUT; n++)
          if (mq[n].size() != 0 && io.io_out_ready[n]) void'(mq[n].pop_front());
        if (acc) begin
          mq[d].push_back(io.io_in_bits);
          m_count = (m_count + 1) % (1 << CW);
          m_rr    = (m_rr + 1) % N_OUT;
        end
      end
      tick();
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
`ifndef DEMUX4_RR_EN
    test_manual_steer();
    test_backpressure();
    test_flow_through();
`else
    test_round_robin();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux4_stream
`default_nettype wire
